change_dispenser: RTL

Sequencing controller for the vending machine's change path. It takes the change amount computed after a vend or cancel and drives the quarter, dime and nickel ejector solenoids one coin at a time, choosing coins greedily. It tracks the fill level of each coin tube and reports the coins dispensed on `quart`/`dim`/`nick`. It sits between the credit/vend FSM, which issues the request, and the coin-mech solenoid drivers.

---
 rtl/vend_pkg.sv | 34 +++
 rtl/change_pulse_timer.sv | 26 ++
 rtl/change_dispenser.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/vend_pkg.sv
// Shared types and constants for the vending machine change path.
package vend_pkg;

    localparam int TUBE_W = 5;
    localparam int AMT_W  = 9;

    localparam logic [AMT_W-1:0] NICKEL_C  = 9'd5;
    localparam logic [AMT_W-1:0] DIME_C    = 9'd10;
    localparam logic [AMT_W-1:0] QUARTER_C = 9'd25;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        PULSE,
        GAP,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        COIN_NONE,
        COIN_Q,
        COIN_D,
        COIN_N
    } coin_t;

    // Tube refill clamps at a full tube instead of wrapping.
    function automatic logic [TUBE_W-1:0] sat_add(input logic [TUBE_W-1:0] a,
                                                  input logic [TUBE_W-1:0] b);
        logic [TUBE_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[TUBE_W] ? '1 : s[TUBE_W-1:0];
    endfunction

endpackage

// File: rtl/change_pulse_timer.sv
// Loadable down-counter timing both the eject pulse and the post-pulse gap.
module change_pulse_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/change_dispenser.sv
// Greedy coin payout sequencer: one solenoid pulse per coin, with tube level tracking.
module change_dispenser
    import vend_pkg::*;
#(
    parameter int PULSE_CYC = 4,
    parameter int GAP_CYC   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req,
    input  logic [8:0] amount,
    input  logic       abort,
    input  logic       load,
    input  logic [4:0] load_q,
    input  logic [4:0] load_d,
    input  logic [4:0] load_n,
    output logic       busy,
    output logic       done,
    output logic       short,
    output logic [8:0] remaining,
    output logic       eject_q,
    output logic       eject_d,
    output logic       eject_n,
    output logic [4:0] quart,
    output logic [4:0] dim,
    output logic [4:0] nick,
    output logic [4:0] lvl_q,
    output logic [4:0] lvl_d,
    output logic [4:0] lvl_n
);

    localparam int TMR_W = 8;

    state_t      state, state_n;
    coin_t       coin, coin_n;
    logic [8:0]  rem_n;
    logic [4:0]  quart_n, dim_n, nick_n;
    logic [4:0]  lvl_q_n, lvl_d_n, lvl_n_n;
    logic        short_r, short_n;
    logic        abort_r, abort_n;
    logic        tmr_load;
    logic [TMR_W-1:0] tmr_val;
    logic        tmr_zero;

    change_pulse_timer #(.W(TMR_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            coin      <= COIN_NONE;
            remaining <= '0;
            quart     <= '0;
            dim       <= '0;
            nick      <= '0;
            lvl_q     <= '0;
            lvl_d     <= '0;
            lvl_n     <= '0;
            short_r   <= 1'b0;
            abort_r   <= 1'b0;
        end else begin
            state     <= state_n;
            coin      <= coin_n;
            remaining <= rem_n;
            quart     <= quart_n;
            dim       <= dim_n;
            nick      <= nick_n;
            lvl_q     <= lvl_q_n;
            lvl_d     <= lvl_d_n;
            lvl_n     <= lvl_n_n;
            short_r   <= short_n;
            abort_r   <= abort_n;
        end
    end

    always_comb begin
        state_n  = state;
        coin_n   = coin;
        rem_n    = remaining;
        quart_n  = quart;
        dim_n    = dim;
        nick_n   = nick;
        lvl_q_n  = lvl_q;
        lvl_d_n  = lvl_d;
        lvl_n_n  = lvl_n;
        short_n  = short_r;
        abort_n  = abort_r;
        tmr_load = 1'b0;
        tmr_val  = '0;

        unique case (state)
            IDLE: begin
                if (req) begin
                    rem_n   = amount;
                    quart_n = '0;
                    dim_n   = '0;
                    nick_n  = '0;
                    short_n = 1'b0;
                    abort_n = 1'b0;
                    state_n = SELECT;
                end else if (load) begin
                    lvl_q_n = sat_add(lvl_q, load_q);
                    lvl_d_n = sat_add(lvl_d, load_d);
                    lvl_n_n = sat_add(lvl_n, load_n);
                end
            end
            SELECT: begin
                if (abort || abort_r || remaining == '0) begin
                    state_n = DONE;
                end else if (remaining >= QUARTER_C && lvl_q != '0) begin
                    coin_n  = COIN_Q;
                    lvl_q_n = lvl_q - 5'd1;
                    quart_n = quart + 5'd1;
                    rem_n   = remaining - QUARTER_C;
                    state_n = PULSE;
                end else if (remaining >= DIME_C && lvl_d != '0) begin
                    coin_n  = COIN_D;
                    lvl_d_n = lvl_d - 5'd1;
                    dim_n   = dim + 5'd1;
                    rem_n   = remaining - DIME_C;
                    state_n = PULSE;
                end else if (remaining >= NICKEL_C && lvl_n != '0) begin
                    coin_n  = COIN_N;
                    lvl_n_n = lvl_n - 5'd1;
                    nick_n  = nick + 5'd1;
                    rem_n   = remaining - NICKEL_C;
                    state_n = PULSE;
                end else begin
                    state_n = DONE;
                end
                if (state_n == PULSE) begin
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(PULSE_CYC - 1);
                end
            end
            PULSE: begin
                if (tmr_zero) begin
                    tmr_load = 1'b1;
                    tmr_val  = TMR_W'(GAP_CYC - 1);
                    state_n  = GAP;
                end
            end
            GAP: begin
                if (tmr_zero) begin
                    coin_n  = COIN_NONE;
                    state_n = SELECT;
                end
            end
            DONE: begin
                short_n = (remaining != '0);
                abort_n = 1'b0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        // Abort latched in PULSE/GAP is acted on at the next SELECT.
        if (abort && state != IDLE && state != DONE) begin
            abort_n = 1'b1;
        end
    end

    assign busy    = (state != IDLE);
    assign done    = (state == DONE);
    assign short   = (state == DONE) ? (remaining != '0) : short_r;
    assign eject_q = (state == PULSE) && (coin == COIN_Q);
    assign eject_d = (state == PULSE) && (coin == COIN_D);
    assign eject_n = (state == PULSE) && (coin == COIN_N);

endmodule
